// File: rtl/sar_adc_ctrl_if.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl_if
// Signal bundle between the SAR controller, the comparator macro and the
// tile I/O.
//   start    : conversion request (level-sampled, accepted only when idle)
//   abort    : synchronous cancel of a running conversion
//   cmp_in   : raw comparator decision, asynchronous to clk
//              (1 = analog input >= DAC level)
//   dac_code : trial code for the reference DAC
//   sample   : high while the analog input is tracked
//   busy     : high from start acceptance through the done cycle
//   done     : one-cycle pulse, result valid on that cycle
//   result   : last completed conversion
// Modports: slave = controller side, master = requester/comparator side.
// ---------------------------------------------------------------------------
interface sar_adc_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             cmp_in;
    logic [WIDTH-1:0] dac_code;
    logic             sample;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, abort, cmp_in,
        input  dac_code, sample, busy, done, result
    );

    modport slave (
        input  start, abort, cmp_in,
        output dac_code, sample, busy, done, result
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation controller: MSB-first binary search of a WIDTH-bit
// code against an external comparator, one bit per SETTLE+DECIDE round.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sar_adc_ctrl_if.slave (start/abort/cmp_in in,
//           dac_code/sample/busy/done/result out)
// ---------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sar_adc_ctrl_if.slave        bus
);

    localparam int unsigned IW   = $clog2(WIDTH);
    localparam int unsigned MAXC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    // Counter only ever holds 0..MAXC-1.
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0]    MSB_IDX     = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          bit_idx;
    logic [WIDTH-1:0]       trial;
    logic [WIDTH-1:0]       dac_code_q;
    logic                   sample_q;
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       result_q;
    logic [SYNC_STAGES-1:0] cmp_sync;

    logic                   cmp_s;
    logic [WIDTH-1:0]       trial_new;
    logic [IW-1:0]          next_idx;

    // Comparator output is asynchronous; only the last stage is trusted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_sync <= '0;
        end else begin
            cmp_sync <= {cmp_sync[SYNC_STAGES-2:0], bus.cmp_in};
        end
    end

    assign cmp_s = cmp_sync[SYNC_STAGES-1];

    // Bit under test is kept only if the input is at or above the trial level.
    always_comb begin
        trial_new = trial;
        if (cmp_s) begin
            trial_new = trial | (ONE << bit_idx);
        end
        next_idx = bit_idx - IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            trial      <= '0;
            dac_code_q <= '0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else if (bus.abort && (state != ST_IDLE)) begin
            // Abort wins over everything else, including a concurrent start.
            state      <= ST_IDLE;
            cnt        <= '0;
            dac_code_q <= '0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= ST_SAMPLE;
                        cnt        <= '0;
                        bit_idx    <= MSB_IDX;
                        trial      <= '0;
                        dac_code_q <= '0;
                        sample_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == SAMPLE_LAST) begin
                        state      <= ST_SETTLE;
                        cnt        <= '0;
                        sample_q   <= 1'b0;
                        dac_code_q <= ONE << MSB_IDX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_DECIDE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DECIDE: begin
                    trial <= trial_new;
                    if (bit_idx != '0) begin
                        bit_idx    <= next_idx;
                        dac_code_q <= trial_new | (ONE << next_idx);
                        state      <= ST_SETTLE;
                    end else begin
                        result_q   <= trial_new;
                        dac_code_q <= trial_new;
                        done_q     <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    sample_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dac_code = dac_code_q;
    assign bus.sample   = sample_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_adc_ctrl
// Directed and random conversions of sar_adc_ctrl (default parameters)
// against an ideal comparator V >= dac_code and a binary-search reference.
// ---------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    localparam int unsigned W = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [7:0]  v_level = 8'h00;
    logic [7:0]  prev_result = 8'h00;
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    sar_adc_ctrl_if #(.WIDTH(W)) bus ();

    sar_adc_ctrl #(
        .WIDTH        (W),
        .SAMPLE_CYCLES(2),
        .SETTLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.cmp_in = (v_level >= bus.dac_code);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},   32'(bus.busy),   32'(0));
        check({tag, " done"},   32'(bus.done),   32'(0));
        check({tag, " sample"}, 32'(bus.sample), 32'(0));
        check({tag, " result"}, 32'(bus.result), 32'(prev_result));
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end
    endtask

    // Entered at a negedge; returns at the negedge after the cycle following done.
    // Cycle n = state after the n-th edge, edge 1 being the accepting edge.
    task automatic convert(input logic [7:0] v, input bit hold, input bit poke);
        logic [7:0] trials [8];
        logic [7:0] acc;
        logic [7:0] t;
        logic [7:0] exp_dac;
        logic [7:0] exp_res;
        acc = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            t = acc | (8'd1 << b);
            trials[7-b] = t;
            if (v >= t) acc = t;
        end
        v_level   = v;
        bus.start = 1'b1;
        for (int n = 1; n <= 44; n++) begin
            @(negedge clk);
            if (n <= 2)       exp_dac = 8'h00;
            else if (n <= 42) exp_dac = trials[(n-3)/5];
            else              exp_dac = acc;
            exp_res = (n >= 43) ? acc : prev_result;
            check($sformatf("v%0h busy@%0d", v, n),   32'(bus.busy),     32'(n <= 43));
            check($sformatf("v%0h done@%0d", v, n),   32'(bus.done),     32'(n == 43));
            check($sformatf("v%0h sample@%0d", v, n), 32'(bus.sample),   32'(n <= 2));
            check($sformatf("v%0h dac@%0d", v, n),    32'(bus.dac_code), 32'(exp_dac));
            check($sformatf("v%0h result@%0d", v, n), 32'(bus.result),   32'(exp_res));
            if (!hold && n == 1) bus.start = 1'b0;
            if (poke && n == 4)  bus.start = 1'b1;
            if (poke && n == 5)  bus.start = 1'b0;
        end
        prev_result = acc;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst dac",    32'(bus.dac_code), 32'(0));
        check("rst sample", 32'(bus.sample),   32'(0));
        check("rst busy",   32'(bus.busy),     32'(0));
        check("rst done",   32'(bus.done),     32'(0));
        check("rst result", 32'(bus.result),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Main example and boundary codes
        convert(8'hA5, 1'b0, 1'b0);
        idle_cycles(2);
        convert(8'h00, 1'b0, 1'b0);
        convert(8'hFF, 1'b0, 1'b0);
        convert(8'h80, 1'b0, 1'b0);

        // start pulsed during SETTLE is ignored
        convert(8'h47, 1'b0, 1'b1);
        idle_cycles(3);

        // start held high: back-to-back conversions with one idle cycle between
        convert(8'h3C, 1'b1, 1'b0);
        convert(8'h3C, 1'b1, 1'b0);
        convert(8'h3C, 1'b1, 1'b0);
        bus.start = 1'b0;
        idle_cycles(2);

        // Abort in the 10th cycle after acceptance, with a concurrent start
        convert(8'h5A, 1'b0, 1'b0);
        v_level   = 8'hE7;
        bus.start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            check($sformatf("abort busy@%0d", n), 32'(bus.busy), 32'(1));
            check($sformatf("abort done@%0d", n), 32'(bus.done), 32'(0));
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_idle("aborted");
        check("aborted dac", 32'(bus.dac_code), 32'(0));
        idle_cycles(3);
        convert(8'hC3, 1'b0, 1'b0);

        // abort while idle has no effect
        bus.abort = 1'b1;
        idle_cycles(2);
        check("idle-abort dac", 32'(bus.dac_code), 32'(8'hC3));
        bus.abort = 1'b0;

        // Asynchronous reset mid-SETTLE
        v_level   = 8'h6D;
        bus.start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst dac",    32'(bus.dac_code), 32'(0));
        check("midrst sample", 32'(bus.sample),   32'(0));
        check("midrst busy",   32'(bus.busy),     32'(0));
        check("midrst done",   32'(bus.done),     32'(0));
        check("midrst result", 32'(bus.result),   32'(0));
        prev_result = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(8'h11, 1'b0, 1'b0);

        // Random levels
        repeat (6) begin
            convert(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            idle_cycles(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation controller that closes the loop around the self-timed dual-input comparator. It drives the reference DAC code toward the comparator's Vin input and consumes the comparator's single-bit Out decision.
- Performs an N-bit binary search per conversion, MSB first, and presents the result with a done pulse.
- Sits between the comparator macro and the tile I/O. dac_code maps to uio_out, and cmp_in is fed from the comparator output.

Parameters:
- WIDTH, 8, conversion resolution in bits (>=2).
- SAMPLE_CYCLES, 2, cycles the sample output is held high at conversion start (>=1).
- SETTLE_CYCLES, 4, cycles waited after each DAC update before the comparator decision is taken (>= SYNC_STAGES+1).
- SYNC_STAGES, 2, flip-flop stages in the cmp_in synchroniser (>=2).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, level-sampled conversion request; accepted only in IDLE.
- abort, input, 1, synchronous cancel; returns to IDLE next cycle.
- cmp_in, input, 1, comparator decision, asynchronous to clk. 1 means analog input >= DAC level.
- dac_code, output, WIDTH, trial code driven to the reference DAC.
- sample, output, 1, high while the analog input is being tracked.
- busy, output, 1, high from start acceptance until the DONE cycle inclusive.
- done, output, 1, one-cycle pulse; result is valid on that cycle.
- result, output, WIDTH, last completed conversion; held until the next done.

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE, dac_code=0, sample=0, busy=0, done=0, result=0, all counters=0, synchroniser flops=0.
- cmp_in passes through a SYNC_STAGES flop chain. Only the last stage (cmp_s) is used by the FSM.
- States are IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE:
  - start=1 at an edge moves to SAMPLE.
  - Bit index i=WIDTH-1, trial register T=0, counter=0.
- SAMPLE:
  - sample=1, dac_code=0.
  - Stays exactly SAMPLE_CYCLES cycles, then moves to SETTLE with dac_code = T | (1<<i).
- SETTLE:
  - dac_code is stable.
  - Stays exactly SETTLE_CYCLES cycles, then moves to DECIDE.
- DECIDE, 1 cycle:
  - If cmp_s=1, keep bit i in T; else clear it.
  - If i>0: decrement i, set dac_code = T_new | (1<<(i-1)), go to SETTLE.
  - If i=0: result<=T_new, go to DONE.
- DONE, 1 cycle:
  - done=1, busy=1, dac_code holds the final T.
  - Next state is IDLE. start is not accepted in this cycle.
- Latency: from the start-accepting edge to the done-high cycle is SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles, which is 42 with defaults. done is visible on the following cycle, 43 edges after acceptance.
- busy=1 in every non-IDLE state.
- start while busy is ignored, with no queuing.
- dac_code in IDLE retains the last final code.
- abort in any non-IDLE state:
  - Next state is IDLE, busy=0, done stays 0.
  - result is unchanged and dac_code=0.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- Reset mid-conversion: immediate return to reset values and no done pulse.
- Width rules:
  - dac_code and result are unsigned WIDTH bits.
  - Bit index counter is ceil(log2(WIDTH)) bits.
  - Cycle counter is wide enough for max(SAMPLE_CYCLES, SETTLE_CYCLES).
  - No wrap-around is permitted in either.

Test Plan:
- Bench comparator model: cmp_in = (V >= dac_code). V=0xA5, pulse start → sequence of dac_code trials 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. done high exactly 43 edges after start; result=0xA5; busy falls the cycle after done.
- Boundary codes: V=0x00 → result 0x00 with final dac_code 0x00. V=0xFF → result 0xFF. V=0x80 → result 0x80.
- start held high continuously with V=0x3C → back-to-back conversions, each result 0x3C. Exactly one idle cycle between done and the next sample=1.
- start pulsed during SETTLE of the first conversion → ignored; a single done, result unchanged from the expected value.
- abort asserted in the 10th cycle after acceptance, with the prior result 0x5A → busy=0 next cycle, no done, result stays 0x5A, dac_code=0. The next start converts normally.
- rst_n asserted asynchronously mid-SETTLE → all outputs zero immediately without a clock edge. After release, V=0x11 converts to 0x11 with normal latency.
